// File: rtl/perceptron_pkg.sv
// Shared types and sizing helpers for the perceptron trainer and evaluator.
package perceptron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DECIDE = 2'd2
    } state_t;

    localparam int N_IN_DEFAULT    = 8;
    localparam int W_WIDTH_DEFAULT = 8;
    localparam int EPOCH_W         = 16;

    // Accumulator must hold N_IN worst-case weights plus a sign bit.
    function automatic int acc_width(input int n_in, input int w_width);
        return w_width + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/perceptron_sat_add.sv
// Signed add of two operands with the result clamped to the output width.
module perceptron_sat_add #(
    parameter int A_W = 8,
    parameter int B_W = 8,
    parameter int Y_W = 8
) (
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [Y_W-1:0] y
);

    localparam int S_W = ((A_W > B_W) ? A_W : B_W) + 1;
    localparam int C_W = (S_W > Y_W) ? S_W : Y_W;

    logic signed [S_W-1:0] sum;
    logic signed [C_W-1:0] sum_ext;
    logic signed [C_W-1:0] y_max;
    logic signed [C_W-1:0] y_min;

    always_comb begin
        sum     = S_W'(a) + S_W'(b);
        sum_ext = C_W'(sum);
        y_max   = C_W'({1'b0, {(Y_W-1){1'b1}}});
        y_min   = ~y_max;
        if (sum_ext > y_max) begin
            y = y_max[Y_W-1:0];
        end else if (sum_ext < y_min) begin
            y = y_min[Y_W-1:0];
        end else begin
            y = sum_ext[Y_W-1:0];
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron trainer: serial dot-product evaluation, learning-rule update,
// epoch counting and convergence tracking.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN     = N_IN_DEFAULT,
    parameter int W_WIDTH  = W_WIDTH_DEFAULT,
    parameter int THR_INIT = 4,
    parameter int LR       = 1,
    localparam int ACC_W   = acc_width(N_IN, W_WIDTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [N_IN-1:0]           s_in,
    input  logic                      s_exp,
    input  logic                      s_last,
    input  logic                      train_en,
    output logic                      res_valid,
    output logic                      res,
    output logic                      err,
    output logic [N_IN*W_WIDTH-1:0]   weights,
    output logic signed [ACC_W-1:0]   thresh,
    output logic                      converged,
    output logic [EPOCH_W-1:0]        epoch_cnt
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t state;
    state_t state_next;

    logic                       accept;
    logic                       accum_en;
    logic                       decide_en;

    logic [N_IN-1:0]            x_q;
    logic                       exp_q;
    logic                       last_q;
    logic                       train_q;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic                       err_seen;
    logic signed [W_WIDTH-1:0]  w_q   [N_IN];
    logic signed [W_WIDTH-1:0]  w_sum [N_IN];
    logic signed [ACC_W-1:0]    thr_sum;

    logic signed [W_WIDTH-1:0]  w_cur;
    logic signed [ACC_W-1:0]    acc_next;
    logic                       res_c;
    logic                       err_c;
    logic                       upd;
    logic signed [W_WIDTH-1:0]  delta;
    logic signed [W_WIDTH-1:0]  neg_delta;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (idx == IDX_W'(N_IN - 1)) begin
                    state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready   = (state == ST_IDLE);
        accept    = (state == ST_IDLE) && s_valid;
        accum_en  = (state == ST_ACCUM);
        decide_en = (state == ST_DECIDE);
    end

    always_comb begin
        w_cur     = w_q[idx];
        acc_next  = acc + ACC_W'(w_cur);
        res_c     = (acc >= thresh);
        err_c     = res_c ^ exp_q;
        upd       = err_c & train_q;
        delta     = exp_q ? W_WIDTH'(LR) : -W_WIDTH'(LR);
        neg_delta = -delta;
    end

    // Candidate updates are always computed; they are committed only on a training error.
    for (genvar i = 0; i < N_IN; i++) begin : g_weight
        perceptron_sat_add #(
            .A_W (W_WIDTH),
            .B_W (W_WIDTH),
            .Y_W (W_WIDTH)
        ) u_sat_w (
            .a (w_q[i]),
            .b (delta),
            .y (w_sum[i])
        );

        assign weights[i*W_WIDTH +: W_WIDTH] = w_q[i];
    end

    perceptron_sat_add #(
        .A_W (ACC_W),
        .B_W (W_WIDTH),
        .Y_W (ACC_W)
    ) u_sat_thr (
        .a (thresh),
        .b (neg_delta),
        .y (thr_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            exp_q     <= 1'b0;
            last_q    <= 1'b0;
            train_q   <= 1'b0;
            idx       <= '0;
            acc       <= '0;
            err_seen  <= 1'b0;
            res_valid <= 1'b0;
            res       <= 1'b0;
            err       <= 1'b0;
            converged <= 1'b0;
            epoch_cnt <= '0;
            thresh    <= ACC_W'(THR_INIT);
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            res_valid <= 1'b0;

            if (accept) begin
                x_q     <= s_in;
                exp_q   <= s_exp;
                last_q  <= s_last;
                train_q <= train_en;
                acc     <= '0;
                idx     <= '0;
            end

            if (accum_en) begin
                if (x_q[idx]) begin
                    acc <= acc_next;
                end
                idx <= idx + IDX_W'(1);
            end

            if (decide_en) begin
                res       <= res_c;
                err       <= err_c;
                res_valid <= 1'b1;
                if (upd) begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (x_q[i]) begin
                            w_q[i] <= w_sum[i];
                        end
                    end
                    thresh <= thr_sum;
                end
                // Epoch boundary folds in this sample's error before judging convergence.
                if (last_q) begin
                    if (epoch_cnt != {EPOCH_W{1'b1}}) begin
                        epoch_cnt <= epoch_cnt + EPOCH_W'(1);
                    end
                    if (!(err_seen | err_c)) begin
                        converged <= 1'b1;
                    end
                    err_seen <= 1'b0;
                end else begin
                    err_seen <= err_seen | err_c;
                end
            end
        end
    end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Online training stage for the perceptron datapath. It accepts labelled samples over a valid/ready handshake and evaluates the current weights with a serial bit-by-bit accumulator. On a misclassification it applies the perceptron learning rule to the weights and threshold. It sits directly upstream of the perceptron evaluator, driving the weight vector and activation threshold it consumes, and tracks epochs and convergence.

## Interface
- `N_IN`, 8: number of binary inputs.
- `W_WIDTH`, 8: signed weight width.
- `ACC_W`, `W_WIDTH+$clog2(N_IN)+1`: signed accumulator and threshold width (derived, not overridden).
- `THR_INIT`, 4: threshold reset value (signed).
- `LR`, 1: learning-rate step (positive integer, ≤ 2^(W_WIDTH-2)).

Ports (one clock, `clk`; reset is synchronous and active-high on port `reset`):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `s_valid` in 1: sample valid.
- `s_ready` out 1: trainer idle, can accept a sample.
- `s_in` in N_IN: binary input vector.
- `s_exp` in 1: expected label.
- `s_last` in 1: sample is last of epoch.
- `train_en` in 1: 1 = update weights on error; 0 = inference only.
- `res_valid` out 1: one-cycle pulse, result fields valid.
- `res` out 1: computed classification.
- `err` out 1: `res != s_exp` for this sample.
- `weights` out N_IN*W_WIDTH: packed signed weights; weight i is in bits [i*W_WIDTH +: W_WIDTH].
- `thresh` out ACC_W: signed activation threshold.
- `converged` out 1: sticky; set when an epoch completes with zero errors.
- `epoch_cnt` out 16: completed epochs, saturating at 0xFFFF.

## Operation
- FSM states: IDLE, ACCUM, DECIDE.
  - IDLE: `s_ready`=1. On `s_valid`: latch `s_in`, `s_exp`, `s_last`, `train_en`; clear `acc` and the bit index; go to ACCUM.
  - ACCUM: each cycle, if latched bit[idx] is 1, add sign-extended w[idx] to `acc`; increment idx. After idx = N_IN-1, go to DECIDE.
  - DECIDE: compute `r = (acc >= thresh)` (signed) and `e = r ^ exp`. Register `res`, `err`, and pulse `res_valid`.
    - If `e` and latched `train_en`: set `d = +LR` if exp=1, else `-LR`. For every i with x_i=1, w_i ← sat(w_i + d). Also thresh ← sat(thresh − d).
    - Saturation bounds: weights to [−2^(W_WIDTH-1), 2^(W_WIDTH-1)−1]; thresh to the ACC_W signed range.
    - Go to IDLE.
- Epoch logic, evaluated in DECIDE:
  - `err_seen` |= e.
  - If latched `s_last`: epoch_cnt++ (saturating). If `err_seen` is 0 after this sample's OR, set `converged`=1. Clear `err_seen`.
  - Convergence is evaluated regardless of `train_en`.
- `s_valid` while not IDLE is ignored (no buffering). Latched fields are unaffected by input changes during ACCUM or DECIDE.
- Reset values: state IDLE, `s_ready`=1, all weights 0, thresh=THR_INIT, `res`=0, `err`=0, `res_valid`=0, `converged`=0, `epoch_cnt`=0, `err_seen`=0, `acc`=0.
- Reset asserted in any state, including mid-ACCUM, aborts the sample. No result is produced, and all state returns to the reset values on the next edge.

## Timing
- Handshake accepted at edge T, so `s_ready` drops in cycle T+1. ACCUM occupies cycles T+1..T+N_IN; DECIDE occupies cycle T+N_IN+1.
- `res`, `err`, `res_valid`=1, the updated `weights`/`thresh`, `epoch_cnt` and `converged` all become visible together in cycle T+N_IN+2. `s_ready`=1 in the same cycle.
- Throughput: one sample per N_IN+2 cycles when `s_valid` is held high.
- `res_valid` is high for exactly one cycle per accepted sample.
- `res` and `err` hold their values until the next DECIDE.
- `weights` and `thresh` are constant between updates, so the downstream evaluator may sample them at any time.

## Structure
- Shared package `perceptron_pkg`: FSM state enum, default `N_IN`/`W_WIDTH`, and an `ACC_W` helper function, reused by the evaluator.
- Sub-module `perceptron_sat_add`: parameterised signed add with clamp to the output width. Instantiated per weight and once for thresh.

## Test plan
- Basic update, N_IN=8, reset state, `train_en`=1: send s_in=0x01, s_exp=1. Required: `res_valid` at T+10, res=0, err=1, w0=1, thresh=3, other weights 0.
- Saturation: repeat s_in=0x01, s_exp=1 until w0=127. One more error sample → w0 stays 127 and thresh decrements by 1.
- Inference only: `train_en`=0, s_in=0xFF, s_exp=1. Required: err=1, weights and thresh unchanged.
- Convergence: train AND of bits 0 and 1 using 4-sample epochs (0x00:0, 0x01:0, 0x02:0, 0x03:1, last on 0x03).
  - `converged` rises on the first zero-error epoch; `epoch_cnt` equals the number of epochs sent.
  - After convergence, weights never change again.
- Reset mid-ACCUM: assert `reset` at T+4. Required: no `res_valid`, all outputs at reset values, `s_ready`=1 the cycle after reset deasserts.
- Back-to-back: `s_valid` held high for 3 samples. Required: acceptances exactly 10 cycles apart and three `res_valid` pulses. An input change during ACCUM does not affect the result.
